// File: rtl/bsg_seq_datapath.sv
// LFSR sequence generator driven by the control core's 2-bit state code.
// Emitted words leave through a small valid/ready circular FIFO.
module bsg_seq_datapath #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
   parameter int               DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 ctrl,
   input  logic [WIDTH-1:0]           seed,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic [7:0]                 step_count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   localparam logic [1:0] CTRL_IDLE = 2'b00;
   localparam logic [1:0] CTRL_LOAD = 2'b01;
   localparam logic [1:0] CTRL_RUN  = 2'b10;
   localparam logic [1:0] CTRL_EMIT = 2'b11;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & TAPS)};
   endfunction

   logic [WIDTH-1:0] lfsr;
   logic [1:0]       prev_ctrl;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level;

   logic emit_entry;
   logic pop;
   logic full;
   logic push;
   logic drop;

   // A held EMIT only pushes on its first cycle.
   assign emit_entry = (ctrl == CTRL_EMIT) && (prev_ctrl != CTRL_EMIT);
   assign full       = (level == LW'(DEPTH));
   assign pop        = out_valid && out_ready;
   assign push       = emit_entry && (!full || pop);
   assign drop       = emit_entry && full && !pop;

   assign out_valid  = (level != '0);
   assign out_data   = out_valid ? mem[rd_ptr] : '0;
   assign fifo_level = level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr       <= WIDTH'(1);
         step_count <= 8'd0;
         overflow   <= 1'b0;
         prev_ctrl  <= CTRL_IDLE;
      end else begin
         prev_ctrl <= ctrl;
         case (ctrl)
            CTRL_LOAD: begin
               lfsr       <= (seed == '0) ? WIDTH'(1) : seed;
               step_count <= 8'd0;
               overflow   <= 1'b0;
            end
            CTRL_RUN: begin
               lfsr       <= lfsr_next(lfsr);
               step_count <= sat_inc(step_count);
            end
            default: begin
               if (drop) overflow <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: out_data is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= lfsr;
   end

endmodule

// File: tb/tb_bsg_seq_datapath.sv
// Randomized and directed bench for bsg_seq_datapath against a queue-based model.
module tb_bsg_seq_datapath;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] ctrl;
   logic [7:0] seed;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic [2:0] fifo_level;
   logic [7:0] step_count;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   bsg_seq_datapath #(.WIDTH(8), .TAPS(8'hB8), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .ctrl(ctrl), .seed(seed), .out_ready(out_ready),
      .out_data(out_data), .out_valid(out_valid), .fifo_level(fifo_level),
      .step_count(step_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model: sequence state plus a plain queue for the FIFO.
   logic [7:0] m_lfsr;
   int         m_cnt;
   logic       m_ovf;
   logic [1:0] m_prev;
   logic [7:0] m_q[$];

   function automatic logic [7:0] ref_next(input logic [7:0] v);
      int ones;
      ones = $countones(v & 8'hB8);
      return {v[6:0], 1'(ones % 2)};
   endfunction

   function automatic logic [7:0] exp_data();
      return (m_q.size() != 0) ? m_q[0] : 8'h00;
   endfunction

   task automatic model_reset();
      m_lfsr = 8'h01; m_cnt = 0; m_ovf = 1'b0; m_prev = 2'b00;
      m_q.delete();
   endtask

   task automatic model_step();
      logic popped;
      popped = (m_q.size() != 0) && out_ready;
      if (popped) void'(m_q.pop_front());
      if (ctrl == 2'b11 && m_prev != 2'b11) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_lfsr);
         else m_ovf = 1'b1;
      end
      if (ctrl == 2'b01) begin
         m_lfsr = (seed == 8'h00) ? 8'h01 : seed;
         m_cnt = 0;
         m_ovf = 1'b0;
      end else if (ctrl == 2'b10) begin
         m_lfsr = ref_next(m_lfsr);
         if (m_cnt < 255) m_cnt++;
      end
      m_prev = ctrl;
   endtask

   task automatic tick();
      if (reset) model_reset();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic [7:0] s, input logic r);
      ctrl = c; seed = s; out_ready = r;
      tick();
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++) drive(2'b00, 8'h00, 1'b1);
      n_cmp++;
      if (fifo_level !== 3'd0) begin
         n_bad++; $display("FAIL drain_empty: fifo_level=%0d required 0", fifo_level);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ctrl = 2'b00; seed = 8'h00; out_ready = 1'b0;
      model_reset();
      tick(); tick();
      n_cmp++;
      if ({out_valid, fifo_level, step_count, overflow, out_data} !== 21'd0) begin
         n_bad++;
         $display("FAIL reset_state: valid=%b level=%0d cnt=%0d ovf=%b data=%h required all 0",
                  out_valid, fifo_level, step_count, overflow, out_data);
      end
      reset = 1'b0;
      drive(2'b11, 8'h00, 1'b0);
      drive(2'b10, 8'h00, 1'b0);
      drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (fifo_level !== 3'd2) begin
         n_bad++; $display("FAIL prereset_level: fifo_level=%0d required 2", fifo_level);
      end
      // Asynchronous assertion away from any clock edge.
      reset = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (out_valid !== 1'b0 || fifo_level !== 3'd0 || step_count !== 8'd0 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: valid=%b level=%0d cnt=%0d ovf=%b required 0 0 0 0",
                  out_valid, fifo_level, step_count, overflow);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h01) begin
         n_bad++; $display("FAIL post_reset_emit: valid=%b data=%h required 1 01", out_valid, out_data);
      end
      drain();
   endtask

   task automatic test_load_run_emit();
      drive(2'b01, 8'h80, 1'b1);
      drive(2'b10, 8'h00, 1'b1);
      drive(2'b11, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || step_count !== 8'd1) begin
         n_bad++;
         $display("FAIL load_run_emit: valid=%b data=%h cnt=%0d required 1 01 1",
                  out_valid, out_data, step_count);
      end
      drive(2'b00, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_cycle_valid: valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_lockup();
      drive(2'b01, 8'h00, 1'b0);
      drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (out_data !== 8'h01) begin
         n_bad++; $display("FAIL zero_seed_guard: data=%h required 01", out_data);
      end
      drain();
      drive(2'b01, 8'hB8, 1'b0);
      drive(2'b10, 8'h00, 1'b0);
      drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (out_data !== 8'h70) begin
         n_bad++; $display("FAIL seed_b8_step: data=%h required 70", out_data);
      end
      drain();
   endtask

   task automatic test_overflow();
      logic [7:0] held;
      drive(2'b01, 8'($urandom_range(1, 255)), 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive(2'b10, 8'h00, 1'b0);
         drive(2'b11, 8'h00, 1'b0);
         drive(2'b00, 8'h00, 1'b0);
      end
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1 || m_q.size() != 4) begin
         n_bad++; $display("FAIL overflow_full: level=%0d ovf=%b required 4 1", fifo_level, overflow);
      end
      held = out_data;
      drive(2'b10, 8'h00, 1'b0);
      n_cmp++;
      if (out_data !== held || out_valid !== 1'b1) begin
         n_bad++; $display("FAIL stall_hold: data=%h valid=%b required %h 1", out_data, out_valid, held);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== exp_data()) begin
            n_bad++; $display("FAIL drain_order[%0d]: data=%h required %h", k, out_data, exp_data());
         end
         drive(2'b00, 8'h00, 1'b1);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || overflow !== 1'b1) begin
         n_bad++; $display("FAIL drained_sticky: valid=%b ovf=%b required 0 1", out_valid, overflow);
      end
      drive(2'b01, 8'h5A, 1'b1);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL load_clears_ovf: ovf=%b required 0", overflow);
      end
   endtask

   task automatic test_back_to_back();
      drive(2'b00, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (fifo_level !== 3'd1) begin
         n_bad++; $display("FAIL held_emit_once: level=%0d required 1", fifo_level);
      end
      for (int k = 0; k < 3; k++) begin
         drive(2'b10, 8'h00, 1'b0);
         drive(2'b11, 8'h00, 1'b0);
         drive(2'b00, 8'h00, 1'b0);
      end
      drive(2'b11, 8'h00, 1'b1);
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0 || out_data !== exp_data()) begin
         n_bad++;
         $display("FAIL full_push_pop: level=%0d ovf=%b data=%h required 4 0 %h",
                  fifo_level, overflow, out_data, exp_data());
      end
      drain();
   endtask

   task automatic test_saturate();
      drive(2'b01, 8'h01, 1'b0);
      for (int k = 0; k < 255; k++) drive(2'b10, 8'h00, 1'b0);
      drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (out_data !== 8'h01 || step_count !== 8'd255) begin
         n_bad++; $display("FAIL period_255: data=%h cnt=%0d required 01 255", out_data, step_count);
      end
      drain();
      drive(2'b01, 8'h3C, 1'b0);
      for (int k = 0; k < 300; k++) drive(2'b10, 8'h00, 1'b0);
      n_cmp++;
      if (step_count !== 8'd255 || m_cnt != 255) begin
         n_bad++; $display("FAIL step_saturate: cnt=%0d required 255", step_count);
      end
      drive(2'b11, 8'h00, 1'b0);
      n_cmp++;
      if (out_data !== exp_data()) begin
         n_bad++; $display("FAIL lfsr_after_300: data=%h required %h", out_data, exp_data());
      end
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         drive(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
         n_cmp++;
         if (out_valid !== (m_q.size() != 0) || fifo_level !== 3'(m_q.size()) ||
             out_data !== exp_data() || step_count !== 8'(m_cnt) || overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL random[%0d]: valid=%b level=%0d data=%h cnt=%0d ovf=%b required %b %0d %h %0d %b",
                     k, out_valid, fifo_level, out_data, step_count, overflow,
                     m_q.size() != 0, m_q.size(), exp_data(), m_cnt, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_run_emit();
      test_lockup();
      test_overflow();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
